// File: rtl/lap_recall_controller.sv
`default_nettype none
// ============================================================================
// Module   : lap_recall_controller
// Purpose  : Captures stopwatch lap times into a circular buffer and switches
//            the display between live time and stored laps. Optional feature
//            macro LAP_OVERWRITE_EN lets a full buffer overwrite its oldest lap.
// Revision : 1.0  initial release
// ============================================================================
module lap_recall_controller #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk_core,
  input  logic             rst,
  input  logic             lap_req,
  input  logic             recall_req,
  input  logic             next_req,
  input  logic             clear_req,
  input  logic [5:0]       min_i,
  input  logic [5:0]       sec_i,
  input  logic [6:0]       ms_10_i,
  output logic [5:0]       min_o,
  output logic [5:0]       sec_o,
  output logic [6:0]       ms_10_o,
  output logic [IDX_W-1:0] lap_idx_o,
  output logic [IDX_W:0]   lap_cnt_o,
  output logic             full_o,
  output logic             recall_o
);

  typedef enum logic [0:0] {
    ST_LIVE   = 1'b0,
    ST_RECALL = 1'b1
  } state_e;

  localparam logic [IDX_W:0]   C_DEPTH   = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] C_IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W:0]   C_CNT_ONE = (IDX_W+1)'(1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   lap_cnt_q, lap_cnt_d;
  logic [IDX_W-1:0] lap_idx_q, lap_idx_d;
  logic [18:0]      mem_q [DEPTH];

  logic             w_full;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_base;
  logic [IDX_W-1:0] w_rd_addr;
  logic [18:0]      w_disp;

  assign w_full = (lap_cnt_q == C_DEPTH);

  // Requests are mutually exclusive by priority: clear > recall > lap > next.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    lap_cnt_d = lap_cnt_q;
    lap_idx_d = lap_idx_q;
    w_wr_en   = 1'b0;
    if (clear_req) begin
      state_d   = ST_LIVE;
      wr_ptr_d  = '0;
      lap_cnt_d = '0;
      lap_idx_d = '0;
    end else if (recall_req) begin
      if (state_q == ST_RECALL) begin
        state_d   = ST_LIVE;
        lap_idx_d = '0;
      end else if (lap_cnt_q != '0) begin
        state_d   = ST_RECALL;
        lap_idx_d = '0;
      end
    end else if (lap_req) begin
      if (state_q == ST_LIVE) begin
        if (!w_full) begin
          w_wr_en   = 1'b1;
          wr_ptr_d  = wr_ptr_q + C_IDX_ONE;
          lap_cnt_d = lap_cnt_q + C_CNT_ONE;
        end else begin
`ifdef LAP_OVERWRITE_EN
          w_wr_en  = 1'b1;
          wr_ptr_d = wr_ptr_q + C_IDX_ONE;
`else
          w_wr_en  = 1'b0;
`endif
        end
      end
    end else if (next_req) begin
      if (state_q == ST_RECALL) begin
        if ({1'b0, lap_idx_q} == (lap_cnt_q - C_CNT_ONE)) begin
          lap_idx_d = '0;
        end else begin
          lap_idx_d = lap_idx_q + C_IDX_ONE;
        end
      end
    end
  end

  // Once wrapped, the oldest surviving lap sits at the write pointer.
`ifdef LAP_OVERWRITE_EN
  assign w_base = (lap_cnt_d == C_DEPTH) ? wr_ptr_d : '0;
`else
  assign w_base = '0;
`endif

  assign w_rd_addr = w_base + lap_idx_d;

  // Display is derived from next-state so every output change lands one cycle after its cause.
  always_comb begin
    w_disp = {min_i, sec_i, ms_10_i};
    if (state_d == ST_RECALL) begin
      w_disp = mem_q[w_rd_addr];
    end
  end

  always_ff @(posedge clk_core) begin
    if (rst) begin
      state_q   <= ST_LIVE;
      wr_ptr_q  <= '0;
      lap_cnt_q <= '0;
      lap_idx_q <= '0;
      min_o     <= '0;
      sec_o     <= '0;
      ms_10_o   <= '0;
      lap_idx_o <= '0;
      lap_cnt_o <= '0;
      full_o    <= 1'b0;
      recall_o  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      lap_cnt_q <= lap_cnt_d;
      lap_idx_q <= lap_idx_d;
      min_o     <= w_disp[18:13];
      sec_o     <= w_disp[12:7];
      ms_10_o   <= w_disp[6:0];
      lap_idx_o <= lap_idx_d;
      lap_cnt_o <= lap_cnt_d;
      full_o    <= (lap_cnt_d == C_DEPTH);
      recall_o  <= (state_d == ST_RECALL);
    end
  end

  // Lap storage carries no reset; entries are only visible once counted.
  always_ff @(posedge clk_core) begin
    if (!rst && w_wr_en) begin
      mem_q[wr_ptr_q] <= {min_i, sec_i, ms_10_i};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lap_recall_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_lap_recall_controller
// Purpose  : Directed and randomized checks of lap_recall_controller against
//            a queue-based lap model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lap_recall_controller;

  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clk_core = 1'b0;
  logic             rst = 1'b1;
  logic             lap_req = 1'b0, recall_req = 1'b0, next_req = 1'b0, clear_req = 1'b0;
  logic [5:0]       min_i = '0, sec_i = '0;
  logic [6:0]       ms_10_i = '0;
  logic [5:0]       min_o, sec_o;
  logic [6:0]       ms_10_o;
  logic [IDX_W-1:0] lap_idx_o;
  logic [IDX_W:0]   lap_cnt_o;
  logic             full_o, recall_o;

  lap_recall_controller #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk_core  (clk_core),
    .rst       (rst),
    .lap_req   (lap_req),
    .recall_req(recall_req),
    .next_req  (next_req),
    .clear_req (clear_req),
    .min_i     (min_i),
    .sec_i     (sec_i),
    .ms_10_i   (ms_10_i),
    .min_o     (min_o),
    .sec_o     (sec_o),
    .ms_10_o   (ms_10_o),
    .lap_idx_o (lap_idx_o),
    .lap_cnt_o (lap_cnt_o),
    .full_o    (full_o),
    .recall_o  (recall_o)
  );

  always #5 clk_core = ~clk_core;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: laps oldest-first in a queue.
  logic [18:0] laps[$];
  bit          m_recall;
  int          m_idx;
  logic [18:0] m_disp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [18:0] tm(input int m, input int s, input int ms);
    return {6'(m), 6'(s), 7'(ms)};
  endfunction

  task automatic model_step(input bit rs, input bit l, input bit r, input bit n,
                            input bit c, input logic [18:0] t);
    if (rs || c) begin
      laps.delete();
      m_recall = 0;
      m_idx    = 0;
    end else if (r) begin
      if (m_recall) begin
        m_recall = 0;
        m_idx    = 0;
      end else if (laps.size() > 0) begin
        m_recall = 1;
        m_idx    = 0;
      end
    end else if (l) begin
      if (!m_recall) begin
        if (laps.size() < DEPTH) laps.push_back(t);
        else begin
`ifdef LAP_OVERWRITE_EN
          void'(laps.pop_front());
          laps.push_back(t);
`endif
        end
      end
    end else if (n) begin
      if (m_recall) m_idx = (m_idx + 1) % laps.size();
    end
    if (rs)            m_disp = '0;
    else if (m_recall) m_disp = laps[m_idx];
    else               m_disp = t;
  endtask

  task automatic cyc(input bit rs, input bit l, input bit r, input bit n,
                     input bit c, input logic [18:0] t);
    rst        = rs;
    lap_req    = l;
    recall_req = r;
    next_req   = n;
    clear_req  = c;
    {min_i, sec_i, ms_10_i} = t;
    @(posedge clk_core);
    model_step(rs, l, r, n, c, t);
    #1;
    check("min",    32'(min_o),     32'(m_disp[18:13]));
    check("sec",    32'(sec_o),     32'(m_disp[12:7]));
    check("ms10",   32'(ms_10_o),   32'(m_disp[6:0]));
    check("idx",    32'(lap_idx_o), 32'(m_recall ? m_idx : 0));
    check("cnt",    32'(lap_cnt_o), 32'(laps.size()));
    check("full",   32'(full_o),    32'(laps.size() == DEPTH));
    check("recall", 32'(recall_o),  32'(m_recall));
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, tm(7, 7, 7));
    cyc(1, 0, 0, 0, 0, tm(7, 7, 7));
    check("rst_min", 32'(min_o), 0);

    // Live passthrough
    cyc(0, 0, 0, 0, 0, tm(1, 2, 3));
    check("live_min", 32'(min_o), 1);
    check("live_sec", 32'(sec_o), 2);
    check("live_ms", 32'(ms_10_o), 3);

    // Three laps, recall, step through with wrap
    cyc(0, 1, 0, 0, 0, tm(0, 5, 10));
    cyc(0, 1, 0, 0, 0, tm(0, 9, 20));
    cyc(0, 1, 0, 0, 0, tm(0, 14, 30));
    cyc(0, 0, 1, 0, 0, tm(3, 3, 3));
    check("rc_sec0", 32'(sec_o), 5);
    check("rc_ms0", 32'(ms_10_o), 10);
    cyc(0, 0, 0, 1, 0, tm(3, 3, 3));
    cyc(0, 0, 0, 1, 0, tm(3, 3, 3));
    check("rc_idx2", 32'(lap_idx_o), 2);
    check("rc_sec2", 32'(sec_o), 14);
    cyc(0, 0, 0, 1, 0, tm(3, 3, 3));
    check("rc_wrap", 32'(lap_idx_o), 0);
    check("rc_wsec", 32'(sec_o), 5);

    // Recall with empty buffer; lap in RECALL
    cyc(0, 0, 0, 0, 1, tm(0, 0, 0));
    cyc(0, 0, 1, 0, 0, tm(0, 0, 0));
    check("empty_rc", 32'(recall_o), 0);
    cyc(0, 1, 0, 0, 0, tm(0, 1, 1));
    cyc(0, 0, 1, 0, 0, tm(0, 0, 0));
    cyc(0, 1, 0, 0, 0, tm(0, 2, 2));
    check("lap_in_rc", 32'(lap_cnt_o), 1);

    // Fill past DEPTH
    cyc(0, 0, 0, 0, 1, tm(0, 0, 0));
    for (int i = 0; i <= DEPTH; i++) cyc(0, 1, 0, 0, 0, tm(0, i, i + 1));
    cyc(0, 0, 1, 0, 0, tm(0, 0, 0));
    check("ovf_full", 32'(full_o), 1);
    check("ovf_cnt", 32'(lap_cnt_o), DEPTH);
`ifdef LAP_OVERWRITE_EN
    check("ovf_idx0", 32'(sec_o), 1);
    for (int i = 0; i < DEPTH - 1; i++) cyc(0, 0, 0, 1, 0, tm(0, 0, 0));
    check("ovf_idx7", 32'(sec_o), 8);
`else
    check("ovf_idx0", 32'(sec_o), 0);
`endif

    // clear + recall together in RECALL with 4 laps
    cyc(0, 0, 0, 0, 1, tm(0, 0, 0));
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, tm(1, i, 50));
    cyc(0, 0, 1, 0, 0, tm(0, 0, 0));
    cyc(0, 0, 1, 0, 1, tm(0, 0, 0));
    check("clr_rc", 32'(recall_o), 0);
    check("clr_cnt", 32'(lap_cnt_o), 0);

    // Reset mid-RECALL
    cyc(0, 1, 0, 0, 0, tm(2, 2, 2));
    cyc(0, 0, 1, 0, 0, tm(0, 0, 0));
    cyc(1, 0, 0, 0, 0, tm(9, 9, 9));
    check("rst_rc", 32'(recall_o), 0);
    check("rst_cnt", 32'(lap_cnt_o), 0);
    cyc(0, 0, 1, 0, 0, tm(0, 0, 0));
    check("rst_norc", 32'(recall_o), 0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      bit rs, l, r, n, c;
      rs = ($urandom_range(0, 199) == 0);
      l  = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 6) == 0);
      n  = ($urandom_range(0, 2) == 0);
      c  = ($urandom_range(0, 39) == 0);
      cyc(rs, l, r, n, c, 19'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
